// File: rtl/enabled_register.sv
// rtl/enabled_register.sv - SIZE-bit load-enabled register, async active-low reset; optional synchronous clear under REGISTER_CLEAR_EN
module enabled_register #(
  parameter int unsigned     SIZE        = 32,
  parameter logic [SIZE-1:0] RESET_VALUE = {SIZE{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [SIZE-1:0] z,
  input  logic [SIZE-1:0] d,
  input  logic            enable
`ifdef REGISTER_CLEAR_EN
  ,
  input  logic            clear
`endif
);

  // Storage flop: reset wins, then clear (when built in), then load, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z <= RESET_VALUE;
    end
`ifdef REGISTER_CLEAR_EN
    else if (clear) begin
      z <= RESET_VALUE;
    end
`endif
    else if (enable) begin
      z <= d;
    end
  end

endmodule

// File: tb/tb_enabled_register.sv
// tb/tb_enabled_register.sv - directed bench for enabled_register (32-bit default and 8-bit/A5 instances)
module tb_enabled_register;

  localparam logic [31:0] RV32 = 32'h0;
  localparam logic [7:0]  RV8  = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] d = 32'd0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] z;
  logic [7:0]  d8 = 8'd0;
  logic        en8 = 1'b0;
  logic [7:0]  z8;

  int vectors = 0;
  int miscompares = 0;
  bit compare_on = 1'b0;

  // expected stored values: the last value accepted since the most recent reset/clear
  logic [31:0] exp32 = RV32;
  logic [7:0]  exp8  = RV8;

  always #5 clk = ~clk;

  enabled_register u_dut32 (
    .clk    (clk),
    .rst_n  (rst_n),
    .z      (z),
    .d      (d),
    .enable (enable)
`ifdef REGISTER_CLEAR_EN
    ,
    .clear  (clear)
`endif
  );

  enabled_register #(.SIZE(8), .RESET_VALUE(RV8)) u_dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .z      (z8),
    .d      (d8),
    .enable (en8)
`ifdef REGISTER_CLEAR_EN
    ,
    .clear  (1'b0)
`endif
  );

  // behavioural model: what each register must be holding after every event
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp32 = RV32;
        exp8  = RV8;
      end else begin
        bit clr;
        clr = 1'b0;
`ifdef REGISTER_CLEAR_EN
        clr = clear;
`endif
        if (clr) exp32 = RV32;
        else if (enable) exp32 = d;
        if (en8) exp8 = d8;
      end
    end
  end

  // every falling edge: DUT outputs against the model
  always @(negedge clk) begin
    if (compare_on) begin
      vectors++;
      if (z !== exp32) begin
        miscompares++;
        $display("FAIL model32 t=%0t z=%0h expected=%0h", $time, z, exp32);
      end
      vectors++;
      if (z8 !== exp8) begin
        miscompares++;
        $display("FAIL model8 t=%0t z8=%0h expected=%0h", $time, z8, exp8);
      end
    end
  end

  task automatic chk32(input string name, input logic [31:0] exp);
    vectors++;
    if (z !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t z=%0h expected=%0h", name, $time, z, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] exp);
    vectors++;
    if (z8 !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t z8=%0h expected=%0h", name, $time, z8, exp);
    end
  endtask

  initial begin
    d = 32'd15;
    #1 rst_n = 1'b0;
    #1;
    chk32("reset_immediate", 32'd0);
    chk8("reset_value8", 8'hA5);
    compare_on = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    d = 32'd15;
    #1 chk32("hold_after_release", 32'd0);

    // loads with enable high; falling edge must not capture
    enable = 1'b1;
    d = 32'd20;
    @(posedge clk); #1 chk32("load_20", 32'd20);
    @(negedge clk); d = 32'd25;
    #1 chk32("no_load_on_fall", 32'd20);
    d = 32'd30;
    @(posedge clk); #1 chk32("load_30", 32'd30);

    // hold with enable low
    @(negedge clk);
    enable = 1'b0;
    d = 32'd45;
    repeat (2) @(posedge clk);
    #1 chk32("hold_30", 32'd30);
    @(negedge clk); enable = 1'b1;
    @(posedge clk); #1 chk32("load_45", 32'd45);

    // async reset between edges with a load pending
    @(negedge clk);
    d = 32'd77;
    #2 rst_n = 1'b0;
    #1 chk32("async_reset", 32'd0);
    repeat (2) @(posedge clk);
    #1 chk32("reset_held", 32'd0);
    chk8("reset_held8", 8'hA5);
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b0;

    // 8-bit instance: full-width load
    d8 = 8'hFF;
    en8 = 1'b1;
    @(posedge clk); #1 chk8("load8_ff", 8'hFF);
    chk32("idle32", 32'd0);
    @(negedge clk); en8 = 1'b0; d8 = 8'h00;
    @(posedge clk); #1 chk8("hold8_ff", 8'hFF);

    // all-ones 32-bit boundary
    @(negedge clk); enable = 1'b1; d = 32'hFFFF_FFFF;
    @(posedge clk); #1 chk32("load_all_ones", 32'hFFFF_FFFF);

    @(negedge clk); d = 32'd30;
    @(posedge clk); #1 chk32("reload_30", 32'd30);
`ifdef REGISTER_CLEAR_EN
    @(negedge clk); clear = 1'b1; enable = 1'b1; d = 32'd99;
    @(posedge clk); #1 chk32("clear_over_enable", 32'd0);
    @(negedge clk); clear = 1'b0;
    @(posedge clk); #1 chk32("load_99_after_clear", 32'd99);
`else
    @(negedge clk); d = 32'd99;
    @(posedge clk); #1 chk32("load_99", 32'd99);
`endif
    @(negedge clk); enable = 1'b0;
    @(negedge clk);
    compare_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
